// File: rtl/router_pkg.sv
// Shared flit layout and port encodings for the deflection router datapath.
package router_pkg;

    localparam int FLIT_W  = 10;
    localparam int VALID_B = 9;
    localparam int AGE_HI  = 8;
    localparam int AGE_LO  = 6;
    localparam int DX_HI   = 5;
    localparam int DX_LO   = 3;
    localparam int DY_HI   = 2;
    localparam int DY_LO   = 0;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [2:0] {
        P_N = 3'd0,
        P_S = 3'd1,
        P_E = 3'd2,
        P_W = 3'd3,
        P_L = 3'd4
    } port_e;

endpackage

// File: rtl/xy_route.sv
// Dimension-ordered (X then Y) productive-port selection for one flit.
module xy_route
    import router_pkg::*;
#(
    parameter logic [2:0] LOCAL_X = 3'd0,
    parameter logic [2:0] LOCAL_Y = 3'd0
) (
    input  logic [2:0] dx,
    input  logic [2:0] dy,
    output port_e      port
);

    // Signed differences avoid constant-result compares when the router sits at an edge coordinate.
    logic [3:0] diff_x;
    logic [3:0] diff_y;

    assign diff_x = {1'b0, dx} - {1'b0, LOCAL_X};
    assign diff_y = {1'b0, dy} - {1'b0, LOCAL_Y};

    always_comb begin
        if (diff_x != 4'd0)      port = diff_x[3] ? P_W : P_E;
        else if (diff_y != 4'd0) port = diff_y[3] ? P_S : P_N;
        else                     port = P_L;
    end

endmodule

// File: rtl/deflect_route.sv
// Two-stage bufferless deflection stage: S1 registers flits and XY ports,
// S2 allocates outputs by age (round-robin on ties) and deflects the losers.
module deflect_route
    import router_pkg::*;
#(
    parameter logic [2:0] LOCAL_X = 3'd0,
    parameter logic [2:0] LOCAL_Y = 3'd0,
    parameter logic [2:0] AGE_MAX = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  nin,
    input  logic [9:0]  sin,
    input  logic [9:0]  ein,
    input  logic [9:0]  win,
    output logic [9:0]  nout,
    output logic [9:0]  sout,
    output logic [9:0]  eout,
    output logic [9:0]  wout,
    output logic [9:0]  lout,
    output logic [15:0] defl_cnt
);

    flit_t      in_flit [4];
    port_e      in_port [4];
    flit_t      s1_flit [4];
    port_e      s1_port [4];
    logic [1:0] rr_ptr;

    assign in_flit[0] = nin;
    assign in_flit[1] = sin;
    assign in_flit[2] = ein;
    assign in_flit[3] = win;

    for (genvar g = 0; g < 4; g++) begin : g_route
        xy_route #(.LOCAL_X(LOCAL_X), .LOCAL_Y(LOCAL_Y)) u_xy (
            .dx   (in_flit[g][DX_HI:DX_LO]),
            .dy   (in_flit[g][DY_HI:DY_LO]),
            .port (in_port[g])
        );
    end

    // Rank: number of other valid flits with a larger {age, round-robin position} key.
    logic [3:0] vld;
    logic [4:0] key  [4];
    logic [2:0] rank [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vld[i] = s1_flit[i][VALID_B];
            key[i] = {s1_flit[i][AGE_HI:AGE_LO], ~(2'(i) - rr_ptr)};
        end
        for (int i = 0; i < 4; i++) begin
            rank[i] = 3'd0;
            for (int j = 0; j < 4; j++)
                if (j != i && vld[j] && key[j] > key[i]) rank[i] = rank[i] + 3'd1;
        end
    end

    flit_t      slot [5];
    logic [4:0] used;
    logic [2:0] n_defl;
    logic       found;
    logic       lost;
    logic [2:0] bumped;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise synthesis infers a latch.
    always_comb begin
        for (int p = 0; p < 5; p++) slot[p] = '0;
        used   = '0;
        n_defl = 3'd0;
        found  = 1'b0;
        lost   = 1'b0;
        bumped = 3'd0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (vld[i] && rank[i] == 3'(r)) begin
                    if (!used[s1_port[i]]) begin
                        slot[s1_port[i]] = s1_flit[i];
                        used[s1_port[i]] = 1'b1;
                    end else begin
                        bumped = (s1_flit[i][AGE_HI:AGE_LO] == AGE_MAX) ? AGE_MAX
                               : s1_flit[i][AGE_HI:AGE_LO] + 3'd1;
                        found  = 1'b0;
                        for (int p = 0; p < 4; p++) begin
                            if (!found && !used[p]) begin
                                found   = 1'b1;
                                used[p] = 1'b1;
                                slot[p] = {1'b1, bumped, s1_flit[i][DX_HI:DY_LO]};
                            end
                        end
                        n_defl = n_defl + 3'd1;
                        lost   = lost | ~found;
                    end
                end
            end
        end
    end

    logic [16:0] cnt_sum;
    assign cnt_sum = {1'b0, defl_cnt} + 17'(n_defl);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                s1_flit[i] <= '0;
                s1_port[i] <= P_N;
            end
            nout     <= '0;
            sout     <= '0;
            eout     <= '0;
            wout     <= '0;
            lout     <= '0;
            defl_cnt <= '0;
            rr_ptr   <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                s1_flit[i] <= in_flit[i][VALID_B] ? in_flit[i] : '0;
                s1_port[i] <= in_port[i];
            end
            nout     <= slot[P_N];
            sout     <= slot[P_S];
            eout     <= slot[P_E];
            wout     <= slot[P_W];
            lout     <= slot[P_L];
            defl_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (|vld) rr_ptr <= rr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!lost);
    end

endmodule

// File: tb/tb_deflect_route.sv
// Scoreboard bench for deflect_route at router (0,0): stimulus pushes expected
// outputs two cycles ahead, a monitor pops and compares them on the falling edge.
module tb_deflect_route;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  nin, sin, ein, win;
    logic [9:0]  nout, sout, eout, wout, lout;
    logic [15:0] defl_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        time         due;
        logic        chk_out;
        logic [9:0]  n, s, e, w, l;
        logic [15:0] defl;
    } exp_t;

    exp_t sb[$];

    deflect_route dut (
        .clk      (clk),
        .rst      (rst),
        .nin      (nin),
        .sin      (sin),
        .ein      (ein),
        .win      (win),
        .nout     (nout),
        .sout     (sout),
        .eout     (eout),
        .wout     (wout),
        .lout     (lout),
        .defl_cnt (defl_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input cycle and queue the response expected two edges later.
    task automatic send(input logic [9:0] n, s, e, w,
                        input logic       chk_out,
                        input logic [9:0] xn, xs, xe, xw, xl,
                        input logic [15:0] xd);
        exp_t x;
        @(negedge clk);
        nin = n; sin = s; ein = e; win = w;
        x.due = $time + 20;
        x.chk_out = chk_out;
        x.n = xn; x.s = xs; x.e = xe; x.w = xw; x.l = xl;
        x.defl = xd;
        sb.push_back(x);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            nin = '0; sin = '0; ein = '0; win = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_nout"}, 16'(nout), 16'h0);
        check({tag, "_sout"}, 16'(sout), 16'h0);
        check({tag, "_eout"}, 16'(eout), 16'h0);
        check({tag, "_wout"}, 16'(wout), 16'h0);
        check({tag, "_lout"}, 16'(lout), 16'h0);
    endtask

    // Monitor: compare every entry whose due time has arrived.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= $time) begin
                x = sb.pop_front();
                if (x.due != $time) begin
                    check("missed_slot", 16'(x.due / 10), 16'($time / 10));
                end else begin
                    if (x.chk_out) begin
                        check("nout", 16'(nout), 16'(x.n));
                        check("sout", 16'(sout), 16'(x.s));
                        check("eout", 16'(eout), 16'(x.e));
                        check("wout", 16'(wout), 16'(x.w));
                        check("lout", 16'(lout), 16'(x.l));
                    end
                    check("defl_cnt", defl_cnt, x.defl);
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_defl;
        int          wait_cnt;

        rst = 1'b1;
        nin = '0; sin = '0; ein = '0; win = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_defl", defl_cnt, 16'h0);
        rst = 1'b0;

        // Tie-break, rr_ptr=0: nin (to 0,1) beats sin (to 0,2); sin deflects to S with age 1.
        send(10'h201, 10'h202, 10'h000, 10'h000, 1'b1,
             10'h201, 10'h242, 10'h000, 10'h000, 10'h000, 16'd1);
        // Same stimulus, rr_ptr=1: sin wins N, nin deflects to S with age 1.
        send(10'h201, 10'h202, 10'h000, 10'h000, 1'b1,
             10'h202, 10'h241, 10'h000, 10'h000, 10'h000, 16'd2);
        // Single flit to (2,0) leaves on E unchanged.
        send(10'h210, 10'h000, 10'h000, 10'h000, 1'b1,
             10'h000, 10'h000, 10'h210, 10'h000, 10'h000, 16'd2);
        // Both want E: ein age 3 wins, win age 1 deflects to N with age 2.
        send(10'h000, 10'h000, 10'h2D0, 10'h250, 1'b1,
             10'h290, 10'h000, 10'h2D0, 10'h000, 10'h000, 16'd3);
        // All local, ages 0/0/5/0: ein ejects, the rest take N, S, E (lowest free) with age 1.
        send(10'h200, 10'h200, 10'h340, 10'h200, 1'b1,
             10'h240, 10'h240, 10'h240, 10'h000, 10'h340, 16'd6);
        // Age 7 tie at rr_ptr=1: ein ranks first and takes E, nin deflects to N keeping age 7.
        send(10'h3D0, 10'h000, 10'h3C8, 10'h000, 1'b1,
             10'h3D0, 10'h000, 10'h3C8, 10'h000, 10'h000, 16'd7);
        // All invalid: everything zero.
        send(10'h000, 10'h000, 10'h000, 10'h000, 1'b1,
             10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 16'd7);
        // Invalid sin with garbage bits is ignored; win ejects locally with age 2.
        send(10'h000, 10'h1FF, 10'h000, 10'h280, 1'b1,
             10'h000, 10'h000, 10'h000, 10'h000, 10'h280, 16'd7);

        // Three deflections per cycle drive the counter through its saturation point.
        exp_defl = 16'd7;
        for (int k = 0; k < 21850; k++) begin
            exp_defl = (exp_defl > 16'hFFFC) ? 16'hFFFF : exp_defl + 16'd3;
            send(10'h200, 10'h200, 10'h200, 10'h200, 1'b0,
                 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, exp_defl);
        end
        idle(1);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("sat_drain", 16'(sb.size()), 16'h0);
        idle(2);
        check("sat_hold", defl_cnt, 16'hFFFF);

        // Reset with valid flits in both stages, then confirm nothing stale emerges.
        @(negedge clk);
        nin = 10'h210; sin = 10'h201; ein = 10'h2D0; win = 10'h250;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        check("midrst_defl", defl_cnt, 16'h0);
        rst = 1'b0;
        nin = '0; sin = '0; ein = '0; win = '0;
        @(negedge clk);
        check_zero("post1");
        @(negedge clk);
        check_zero("post2");

        send(10'h210, 10'h000, 10'h000, 10'h000, 1'b1,
             10'h000, 10'h000, 10'h210, 10'h000, 10'h000, 16'd0);
        idle(1);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("final_drain", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
